// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared state type, NUM_CH bounds and slot-counter width helper
package tdm_demux_pkg;
  typedef enum logic {HUNT, LOCKED} state_e;
  localparam int NUM_CH_MIN = 2;
  localparam int NUM_CH_MAX = 16;
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: modulo-NUM_CH slot counter with clear, load-to-1 and advance
module tdm_slot_counter
  import tdm_demux_pkg::*;
#(
  parameter int NUM_CH = 7,
  parameter int W = cnt_w(NUM_CH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         advance_i,
  input  logic         load1_i,
  input  logic         clear_i,
  output logic [W-1:0] slot_cnt_o,
  output logic         is_last_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign is_last_o = cnt_q == W'(NUM_CH - 1);
  assign slot_cnt_o = cnt_q;
  always_comb
    cnt_d = clear_i ? '0 : load1_i ? W'(1) : advance_i ? (is_last_o ? '0 : cnt_q + W'(1)) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: serial TDM to parallel frame demultiplexer; TDM_DEMUX_STRICT_SYNC_EN makes a missing slot-0 sync drop lock
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int NUM_CH = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [NUM_CH-1:0] ch_out,
  output logic              frame_valid,
  output logic              sync_err,
  output logic              locked
);
  localparam int W = cnt_w(NUM_CH);
`ifdef TDM_DEMUX_STRICT_SYNC_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif
  state_e state_q, state_d;
  logic [NUM_CH-2:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] ch_out_q, ch_out_d;
  logic frame_valid_q, frame_valid_d, sync_err_q, sync_err_d;
  logic advance, load1, clear, is_last;
  logic [W-1:0] slot_cnt;
  tdm_slot_counter #(.NUM_CH(NUM_CH), .W(W)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance_i (advance),
    .load1_i   (load1),
    .clear_i   (clear),
    .slot_cnt_o(slot_cnt),
    .is_last_o (is_last)
  );
  always_comb begin
    state_d = state_q;
    shadow_d = shadow_q;
    ch_out_d = ch_out_q;
    frame_valid_d = 1'b0;
    sync_err_d = 1'b0;
    advance = 1'b0;
    load1 = 1'b0;
    clear = 1'b0;
    if (din_valid) begin
      if (state_q == HUNT) begin
        if (frame_sync) begin
          shadow_d[0] = din;
          load1 = 1'b1;
          state_d = LOCKED;
        end
      end else if (frame_sync && slot_cnt != '0) begin
        // resync: the beat becomes slot 0 of a fresh frame
        sync_err_d = 1'b1;
        shadow_d[0] = din;
        load1 = 1'b1;
      end else if (STRICT && !frame_sync && slot_cnt == '0) begin
        sync_err_d = 1'b1;
        clear = 1'b1;
        state_d = HUNT;
      end else begin
        for (int i = 0; i < NUM_CH - 1; i++)
          if (int'(slot_cnt) == i) shadow_d[i] = din;
        advance = 1'b1;
        if (is_last) begin
          ch_out_d = {din, shadow_q};
          frame_valid_d = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= HUNT;
      shadow_q <= '0;
      ch_out_q <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shadow_q <= shadow_d;
      ch_out_q <= ch_out_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q <= sync_err_d;
    end
  assign ch_out = ch_out_q;
  assign frame_valid = frame_valid_q;
  assign sync_err = sync_err_q;
  assign locked = state_q == LOCKED;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed self-checking bench for tdm_demux with NUM_CH=7
module tb_tdm_demux;
  localparam int N = 7;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic frame_sync = 1'b0;
  logic [N-1:0] ch_out;
  logic frame_valid, sync_err, locked;
  int checks = 0;
  int failures = 0;
  tdm_demux #(.NUM_CH(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .ch_out     (ch_out),
    .frame_valid(frame_valid),
    .sync_err   (sync_err),
    .locked     (locked)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic v, input logic d, input logic fs);
    @(negedge clk);
    din_valid = v;
    din = d;
    frame_sync = fs;
    @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input string tag, input logic [N-1:0] b, input logic fs0, input bit gap, input logic se0);
    logic [N-1:0] prev;
    prev = ch_out;
    for (int i = 0; i < N; i++) begin
      step(1'b1, b[i], fs0 && i == 0);
      chk({tag, "_fv"}, frame_valid, i == N - 1);
      chk({tag, "_se"}, sync_err, (i == 0) ? se0 : 1'b0);
      chk({tag, "_lk"}, locked, 1'b1);
      if (i < N - 1) chk({tag, "_hold"}, ch_out, prev);
      if (gap && i < N - 1) begin
        step(1'b0, ~b[i], 1'b1);
        chk({tag, "_gap_fv"}, frame_valid, 1'b0);
        chk({tag, "_gap_hold"}, ch_out, prev);
      end
    end
    chk({tag, "_data"}, ch_out, b);
    step(1'b0, 1'b0, 1'b0);
    chk({tag, "_fv_pulse"}, frame_valid, 1'b0);
    chk({tag, "_data_held"}, ch_out, b);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ch_out", ch_out, '0);
    chk("rst_fv", frame_valid, 1'b0);
    chk("rst_se", sync_err, 1'b0);
    chk("rst_lk", locked, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("hunt_fv", frame_valid, 1'b0);
      chk("hunt_se", sync_err, 1'b0);
      chk("hunt_lk", locked, 1'b0);
    end
    send_frame("frameA", 7'b1001101, 1'b1, 1'b0, 1'b0);
    send_frame("gapped", 7'b1001101, 1'b1, 1'b1, 1'b0);
    send_frame("gapped2", 7'b0110010, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("pre_resync_se", sync_err, 1'b0);
    send_frame("resync", 7'b0010110, 1'b1, 1'b0, 1'b1);
    send_frame("frameC", 7'b1110000, 1'b1, 1'b0, 1'b0);
`ifdef TDM_DEMUX_STRICT_SYNC_EN
    step(1'b1, 1'b1, 1'b0);
    chk("strict_se", sync_err, 1'b1);
    chk("strict_lk", locked, 1'b0);
    chk("strict_fv", frame_valid, 1'b0);
    for (int i = 0; i < N - 1; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("strict_no_fv", frame_valid, 1'b0);
      chk("strict_no_se", sync_err, 1'b0);
      chk("strict_data", ch_out, 7'b1110000);
    end
`else
    send_frame("flywheel", 7'b0101011, 1'b0, 1'b0, 1'b0);
`endif
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ch_out", ch_out, '0);
    chk("arst_fv", frame_valid, 1'b0);
    chk("arst_se", sync_err, 1'b0);
    chk("arst_lk", locked, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("arst_hold_lk", locked, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("post_rst_hunt_fv", frame_valid, 1'b0);
      chk("post_rst_hunt_lk", locked, 1'b0);
      chk("post_rst_hunt_se", sync_err, 1'b0);
    end
    send_frame("frameE", 7'b1010010, 1'b1, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
